m_cache_refill: RTL and testbench
=================================

# m_cache_refill

Line-refill engine driving the install port of the 4-word write-noallocate data cache. On a read miss it latches the miss address, fetches the 16-byte line from the memory side as four 32-bit beats, assembles it into a 128-bit line, and then issues a single-cycle install (enable, address, data) to the cache. It sits between the cache's miss signalling and the memory bus, and holds the core stalled through `o_busy` until the line is installed.

## Interface
- `DADDR_WIDTH` (from `define.v`): data address width; `DADDR` is `[DADDR_WIDTH-1:0]`.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_miss` in 1: read miss request, level; sampled only in IDLE.
- `i_maddr` in `DADDR`: miss address; bits [3:0] ignored, except [3:2] under `CACHE_REFILL_CWF_EN`.
- `i_wbusy` in 1: cache delayed-write pending (cache `o_we`); install must not coincide with it.
- `o_busy` out 1: refill in progress (any state except IDLE).
- `o_mreq` out 1: memory beat request, held until acknowledged.
- `o_maddr` out `DADDR`: beat word address, {line, beat, 2'b00}.
- `i_mack` in 1: memory accepts the beat; `i_mdata` is valid in the same cycle.
- `i_mdata` in 32: beat data.
- `o_ie` out 1: cache install enable, one-cycle pulse.
- `o_iaddr` out `DADDR`: install address, {line, 4'b0}.
- `o_idata` out 128: install line; word k occupies bits [k*32 +: 32].
- `o_cwvalid` out 1: critical word available. Only exists with `CACHE_REFILL_CWF_EN`.
- `o_cwdata` out 32: critical word. Only exists with `CACHE_REFILL_CWF_EN`.

## Operation
- States: IDLE, FETCH, HOLD, INSTALL.
- IDLE:
  - If `i_miss`=1, latch line address = `i_maddr[DADDR_WIDTH-1:4]`.
  - Set start beat to 0, or to `i_maddr[3:2]` with CWF.
  - Clear beat count, go to FETCH.
- FETCH:
  - `o_mreq`=1, `o_maddr` = {line, beat, 2'b00}.
  - On `i_mack`, write `i_mdata` into word `beat` of the line buffer, then beat <= beat+1 (2-bit, wraps 3→0) and count <= count+1.
  - After the 4th ack, go to HOLD if `i_wbusy`=1, else go to INSTALL.
  - `o_mreq` drops in the cycle after the 4th ack.
- HOLD: wait while `i_wbusy`=1; go to INSTALL on the first cycle it is 0.
- INSTALL:
  - `o_ie`=1 for exactly one cycle, with `o_iaddr` and `o_idata` stable.
  - Next state is IDLE. `i_miss` is not accepted in this cycle.
- `i_miss` is ignored while `o_busy`=1. A miss still asserted on the cycle after INSTALL starts a new refill; the cache then reports a hit, so the core must drop `i_miss`.
- `o_idata` and `o_iaddr` are registered and valid whenever `o_ie`=1. Outside that pulse their values are don't-care but stable.
- Reset mid-operation:
  - Return immediately to IDLE.
  - All outputs 0, line buffer cleared.
  - A beat in flight is abandoned; the memory side must tolerate a dropped request.

## Timing
- Reset values: `o_busy`, `o_mreq`, `o_ie`, `o_cwvalid` = 0; `o_maddr`, `o_iaddr`, `o_idata`, `o_cwdata` = 0.
- All outputs are registered or decoded directly from the state register; no combinational path from `i_mack` to any output.
- Miss accepted at edge N: `o_busy` and `o_mreq` are high after edge N.
- Zero-wait memory (`i_mack` tied high): beats complete at edges N+1..N+4, `o_ie` pulses after N+4, and IDLE is reached after N+5. Miss-to-install is therefore 5 cycles.
- Each wait cycle on `i_mack` adds one cycle.
- Each cycle of `i_wbusy` seen at FETCH exit or in HOLD adds one cycle.
- `o_ie` is never high in a cycle where `i_wbusy`=1.

## Configuration
- `CACHE_REFILL_CWF_EN` defined:
  - Critical-word-first: the first beat is word `i_maddr[3:2]`, and beats wrap modulo 4.
  - `o_cwvalid` pulses one cycle after the first ack, with `o_cwdata` = that word, so the core can restart before install.
- Not defined:
  - Beats are always in order 0,1,2,3.
  - `o_cwvalid` and `o_cwdata` are absent.
  - `i_maddr[3:2]` is ignored.

## Structure
- `define.v` holds `DADDR`/`DADDR_WIDTH`, the state encodings (`REFILL_IDLE`, `REFILL_FETCH`, `REFILL_HOLD`, `REFILL_INSTALL`, 2-bit) and `CACHE_LINE_WORDS` = 4.
- One sub-module, `m_refill_linebuf`: a 4×32 assembly register with word write enable, word index and clear, outputting the 128-bit line.

## Test plan
- Zero-wait refill, CWF off:
  - Stimulus: miss at 0x0000_1234; memory returns 0xA0,0xA1,0xA2,0xA3 for addresses 0x1230,0x1234,0x1238,0x123C.
  - Required: `o_ie` 5 cycles after acceptance, `o_iaddr`=0x1230, `o_idata`=0x000000A3_000000A2_000000A1_000000A0.
- Wait states:
  - Stimulus: `i_mack` low 2 cycles before each beat.
  - Required: install 13 cycles after acceptance, `o_mreq` held and `o_maddr` stable through waits.
- Write collision:
  - Stimulus: `i_wbusy`=1 for 3 cycles spanning the end of FETCH.
  - Required: state HOLD, `o_ie` on the first cycle `i_wbusy`=0, never overlapping.
- CWF on:
  - Stimulus: miss at 0x0000_1238.
  - Required: beat order 0x1238,0x123C,0x1230,0x1234; `o_cwvalid` with the 0x1238 data; `o_idata` word order identical to the CWF-off case.
- Reset mid-FETCH:
  - Stimulus: deassert `i_rst_n` after 2 beats.
  - Required: all outputs 0 asynchronously; a new miss afterwards fetches all 4 beats with no stale words.
- Busy miss:
  - Stimulus: change `i_maddr` and keep `i_miss` high during FETCH.
  - Required: original line installed; next refill starts only after INSTALL.

Source files
------------

// File: rtl/m_cache_refill_pkg.sv
// m_cache_refill_pkg: widths, line geometry and FSM encoding shared by the
// line-refill engine and its line assembly buffer.
package m_cache_refill_pkg;

   localparam int DADDR_WIDTH      = 32;
   localparam int CACHE_LINE_WORDS = 4;
   localparam int WORD_WIDTH       = 32;
   localparam int LINE_WIDTH       = CACHE_LINE_WORDS * WORD_WIDTH;
   localparam int WIDX_WIDTH       = $clog2(CACHE_LINE_WORDS);
   localparam int LINE_ADDR_WIDTH  = DADDR_WIDTH - 4;

   typedef logic [DADDR_WIDTH-1:0] daddr_t;

   typedef enum logic [1:0] {
      REFILL_IDLE    = 2'd0,
      REFILL_FETCH   = 2'd1,
      REFILL_HOLD    = 2'd2,
      REFILL_INSTALL = 2'd3
   } refill_state_t;

endpackage

// File: rtl/m_refill_linebuf.sv
// m_refill_linebuf: 4 x 32-bit line assembly register. Words are written one
// at a time by index; the whole line can be cleared; word k is presented at
// bits [k*32 +: 32] of the flattened line.
module m_refill_linebuf
   import m_cache_refill_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [WIDX_WIDTH-1:0] i_idx,
   input  logic [WORD_WIDTH-1:0] i_wdata,
   output logic [LINE_WIDTH-1:0] o_line
);

   logic [WORD_WIDTH-1:0] r_words [CACHE_LINE_WORDS];

   // Word storage: cleared by reset or at refill start, else one word per write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: this small array is reset deliberately so a refill aborted by
         // reset can never leave a stale word behind; a large RAM would not be.
         for (int k = 0; k < CACHE_LINE_WORDS; k++) begin
            r_words[k] <= '0;
         end
      end else if (i_clr) begin
         for (int k = 0; k < CACHE_LINE_WORDS; k++) begin
            r_words[k] <= '0;
         end
      end else if (i_we) begin
         // NOTE: non-blocking assignments for all clocked state, so every
         // register samples pre-edge values regardless of statement order.
         r_words[i_idx] <= i_wdata;
      end
   end

   // Flatten the words into the install line, word k at bits [k*32 +: 32].
   always_comb begin
      // NOTE: default assignment first so no path through the block can
      // leave the output unassigned and infer a latch.
      o_line = '0;
      for (int k = 0; k < CACHE_LINE_WORDS; k++) begin
         o_line[k*WORD_WIDTH +: WORD_WIDTH] = r_words[k];
      end
   end

endmodule

// File: rtl/m_cache_refill.sv
// m_cache_refill: line-refill engine for the write-noallocate data cache.
// Latches a read-miss line address, fetches four 32-bit beats from memory,
// assembles them and issues a one-cycle install to the cache, holding the
// core through o_busy. Optional macro CACHE_REFILL_CWF_EN enables
// critical-word-first fetch order and the o_cwvalid/o_cwdata outputs.
module m_cache_refill
   import m_cache_refill_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_miss,
   input  logic [DADDR_WIDTH-1:0] i_maddr,
   input  logic                  i_wbusy,
   output logic                  o_busy,
   output logic                  o_mreq,
   output logic [DADDR_WIDTH-1:0] o_maddr,
   input  logic                  i_mack,
   input  logic [WORD_WIDTH-1:0] i_mdata,
   output logic                  o_ie,
   output logic [DADDR_WIDTH-1:0] o_iaddr,
`ifdef CACHE_REFILL_CWF_EN
   output logic                  o_cwvalid,
   output logic [WORD_WIDTH-1:0] o_cwdata,
`endif
   output logic [LINE_WIDTH-1:0] o_idata
);

   refill_state_t              r_state;
   refill_state_t              w_next_state;
   logic [LINE_ADDR_WIDTH-1:0] r_line;
   logic [WIDX_WIDTH-1:0]      r_beat;
   logic [WIDX_WIDTH-1:0]      r_count;
   logic                       w_accept;
   logic                       w_beat_ack;
   logic                       w_last_ack;
   logic                       w_unused_maddr;

   // A miss is only looked at in IDLE; acks only count while fetching.
   assign w_accept       = (r_state == REFILL_IDLE) && i_miss;
   assign w_beat_ack     = (r_state == REFILL_FETCH) && i_mack;
   assign w_last_ack     = w_beat_ack && (r_count == WIDX_WIDTH'(CACHE_LINE_WORDS - 1));
   // Byte offset bits never address anything here.
   assign w_unused_maddr = ^i_maddr[3:0];

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= REFILL_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: fetch four beats, wait out a pending cache write, install once.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         REFILL_IDLE: begin
            if (i_miss) w_next_state = REFILL_FETCH;
         end
         REFILL_FETCH: begin
            if (w_last_ack) w_next_state = i_wbusy ? REFILL_HOLD : REFILL_INSTALL;
         end
         REFILL_HOLD: begin
            if (!i_wbusy) w_next_state = REFILL_INSTALL;
         end
         REFILL_INSTALL: begin
            w_next_state = REFILL_IDLE;
         end
         default: begin
            w_next_state = REFILL_IDLE;
         end
      endcase
   end

   // Control outputs decoded straight from the state register.
   always_comb begin
      o_busy = 1'b0;
      o_mreq = 1'b0;
      o_ie   = 1'b0;
      case (r_state)
         REFILL_FETCH:   begin o_busy = 1'b1; o_mreq = 1'b1; end
         REFILL_HOLD:    begin o_busy = 1'b1; end
         REFILL_INSTALL: begin o_busy = 1'b1; o_ie = 1'b1; end
         default:        begin end
      endcase
   end

   // Refill bookkeeping: line and start beat captured on accept, beat index
   // wraps modulo 4 and the beat count advances on every ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_line  <= '0;
         r_beat  <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_line  <= i_maddr[DADDR_WIDTH-1:4];
`ifdef CACHE_REFILL_CWF_EN
         r_beat  <= i_maddr[3:2];
`else
         r_beat  <= '0;
`endif
         r_count <= '0;
      end else if (w_beat_ack) begin
         r_beat  <= r_beat + WIDX_WIDTH'(1);
         r_count <= r_count + WIDX_WIDTH'(1);
      end
   end

   // Beat and install addresses come from registers only, never from i_mack.
   assign o_maddr = {r_line, r_beat, 2'b00};
   assign o_iaddr = {r_line, 4'b0000};

   m_refill_linebuf u_linebuf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_accept),
      .i_we    (w_beat_ack),
      .i_idx   (r_beat),
      .i_wdata (i_mdata),
      .o_line  (o_idata)
   );

`ifdef CACHE_REFILL_CWF_EN
   logic                  r_cwvalid;
   logic [WORD_WIDTH-1:0] r_cwdata;
   logic                  w_first_ack;

   assign w_first_ack = w_beat_ack && (r_count == '0);

   // Critical word: flag the first returned beat for one cycle and hold it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cwvalid <= 1'b0;
         r_cwdata  <= '0;
      end else begin
         r_cwvalid <= w_first_ack;
         if (w_first_ack) r_cwdata <= i_mdata;
      end
   end

   assign o_cwvalid = r_cwvalid;
   assign o_cwdata  = r_cwdata;
`endif

endmodule

// File: tb/tb_m_cache_refill.sv
// tb_m_cache_refill: table-driven and randomized bench for m_cache_refill.
// A memory responder serves beats with a programmable number of wait cycles;
// expected beat order, install latency, HOLD length and line contents are
// derived from the refill rules by a small model.
module tb_m_cache_refill;
   import m_cache_refill_pkg::*;

   logic         i_clk;
   logic         i_rst_n;
   logic         i_miss;
   logic [31:0]  i_maddr;
   logic         i_wbusy;
   logic         o_busy;
   logic         o_mreq;
   logic [31:0]  o_maddr;
   logic         i_mack;
   logic [31:0]  i_mdata;
   logic         o_ie;
   logic [31:0]  o_iaddr;
   logic [127:0] o_idata;
`ifdef CACHE_REFILL_CWF_EN
   logic         o_cwvalid;
   logic [31:0]  o_cwdata;
`endif

   m_cache_refill dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_miss    (i_miss),
      .i_maddr   (i_maddr),
      .i_wbusy   (i_wbusy),
      .o_busy    (o_busy),
      .o_mreq    (o_mreq),
      .o_maddr   (o_maddr),
      .i_mack    (i_mack),
      .i_mdata   (i_mdata),
      .o_ie      (o_ie),
      .o_iaddr   (o_iaddr),
`ifdef CACHE_REFILL_CWF_EN
      .o_cwvalid (o_cwvalid),
      .o_cwdata  (o_cwdata),
`endif
      .o_idata   (o_idata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One refill: stimulus fields followed by model-derived expectations.
   typedef struct {
      logic [31:0]       addr;
      int                waits;
      int                wb_start;
      int                wb_len;
      logic [3:0][31:0]  data;
      bit                keep_miss;
      logic [31:0]       alt_addr;
      int                exp_lat;
      int                exp_hold;
      logic [31:0]       exp_iaddr;
      logic [127:0]      exp_idata;
      logic [3:0][31:0]  exp_order;
   } vec_t;

   // i_wbusy is high during bench cycles [wb_start, wb_start+wb_len).
   function automatic bit wb_high(input vec_t v, input int c);
      return (c >= v.wb_start) && (c < v.wb_start + v.wb_len);
   endfunction

   // Reference model: beat j fetches word (start+j) mod 4; the 4th ack lands
   // at edge 4*(waits+1) after acceptance; every consecutive busy cycle seen
   // from that edge on delays the install by one.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int   start;
      int   e4;
      int   extra;
      r     = v;
      start = 0;
`ifdef CACHE_REFILL_CWF_EN
      start = int'(v.addr[3:2]);
`endif
      for (int j = 0; j < 4; j++) begin
         r.exp_order[j] = {v.addr[31:4], 4'b0000} + 32'(((start + j) % 4) * 4);
      end
      e4    = 4 * (v.waits + 1);
      extra = 0;
      while (wb_high(v, e4 - 1 + extra)) extra++;
      r.exp_hold  = extra;
      r.exp_lat   = e4 + extra + 1;
      r.exp_iaddr = {v.addr[31:4], 4'b0000};
      r.exp_idata = v.data;
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] addr, input int waits, input int wbs,
                               input int wbl, input logic [127:0] data,
                               input bit keep, input logic [31:0] alt);
      vec_t v;
      v.addr      = addr;
      v.waits     = waits;
      v.wb_start  = wbs;
      v.wb_len    = wbl;
      v.data      = data;
      v.keep_miss = keep;
      v.alt_addr  = alt;
      return model(v);
   endfunction

   // Drive one refill from miss to the IDLE cycle after install and compare.
   // Time on entry/exit: a negedge (away from the active edge).
   task automatic run_refill(input vec_t v, input string tag);
      int          e, wait_cnt, nbeats, ie_e, ie_cnt, hold_cyc, overlap, unstable;
      int          first_ack_e;
      bit          done, have_cur;
      logic [31:0] cur_addr, iaddr;
      logic [127:0] idata;
      logic [31:0] beats [4];
`ifdef CACHE_REFILL_CWF_EN
      int          cw_cnt, cw_e;
      logic [31:0] cw_data;
      cw_cnt = 0; cw_e = -1; cw_data = '0;
`endif
      e = 0; wait_cnt = 0; nbeats = 0; ie_e = -1; ie_cnt = 0; hold_cyc = 0;
      overlap = 0; unstable = 0; first_ack_e = -1; done = 0; have_cur = 0;
      cur_addr = '0; iaddr = '0; idata = '0;
      for (int j = 0; j < 4; j++) beats[j] = '0;

      i_miss  = 1'b1;
      i_maddr = v.addr;
      @(posedge i_clk); #1;
      i_miss = v.keep_miss;
      if (v.keep_miss) i_maddr = v.alt_addr;

      while (!done && e < 200) begin
         i_wbusy = wb_high(v, e);
         i_mack  = 1'b0;
         i_mdata = $urandom;
         if (o_mreq && ie_e < 0) begin
            if (!have_cur) begin
               cur_addr = o_maddr;
               have_cur = 1;
            end else if (o_maddr !== cur_addr) begin
               unstable++;
            end
            if (wait_cnt < v.waits) begin
               wait_cnt++;
            end else begin
               i_mack  = 1'b1;
               i_mdata = v.data[o_maddr[3:2]];
               if (nbeats < 4) beats[nbeats] = o_maddr;
               if (nbeats == 0) first_ack_e = e;
               nbeats++;
               wait_cnt = 0;
               have_cur = 0;
            end
         end
         @(negedge i_clk);
         if (o_ie) begin
            ie_cnt++;
            if (i_wbusy) overlap++;
            if (ie_e < 0) begin
               ie_e  = e;
               iaddr = o_iaddr;
               idata = o_idata;
            end
         end
         if (o_busy && !o_mreq && !o_ie) hold_cyc++;
`ifdef CACHE_REFILL_CWF_EN
         if (o_cwvalid) begin
            cw_cnt++;
            cw_e    = e;
            cw_data = o_cwdata;
         end
`endif
         if (ie_e >= 0 && e == ie_e + 1) begin
            check({tag, " busy after install"}, o_busy, 1'b0);
            done = 1;
         end else begin
            @(posedge i_clk); #1;
            e++;
         end
      end
      i_wbusy = 1'b0;
      i_mack  = 1'b0;

      check({tag, " finished in budget"}, done, 1'b1);
      check({tag, " beat count"}, nbeats, 4);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("%s beat%0d addr", tag, j), beats[j], v.exp_order[j]);
      end
      check({tag, " miss-to-install cycles"}, ie_e + 1, v.exp_lat);
      check({tag, " install pulses"}, ie_cnt, 1);
      check({tag, " iaddr"}, iaddr, v.exp_iaddr);
      check({tag, " idata"}, idata, v.exp_idata);
      check({tag, " ie with wbusy"}, overlap, 0);
      check({tag, " maddr unstable in wait"}, unstable, 0);
      check({tag, " hold cycles"}, hold_cyc, v.exp_hold);
`ifdef CACHE_REFILL_CWF_EN
      check({tag, " cwvalid pulses"}, cw_cnt, 1);
      check({tag, " cwvalid timing"}, cw_e, first_ack_e + 1);
      check({tag, " cwdata"}, cw_data, v.data[v.addr[3:2]]);
`endif
   endtask

   vec_t vecs [7];
   vec_t rv;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Directed table: zero-wait, wait states, write collision, CWF address,
      // busy miss followed by the chained refill, long HOLD at the top line.
      vecs[0] = mk(32'h0000_1234, 0, 0, 0,
                   {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}, 0, '0);
      vecs[1] = mk(32'h2000_1234, 2, 0, 0,
                   {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000}, 0, '0);
      vecs[2] = mk(32'h0000_4440, 0, 2, 3,
                   {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}, 0, '0);
      vecs[3] = mk(32'h0000_1238, 0, 0, 0,
                   {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1, 32'h0000_00B0}, 0, '0);
      vecs[4] = mk(32'h0000_7700, 1, 0, 0,
                   {32'h7700_0003, 32'h7700_0002, 32'h7700_0001, 32'h7700_0000}, 1, 32'h0000_9914);
      vecs[5] = mk(32'h0000_9914, 0, 0, 0,
                   {32'h9910_0003, 32'h9910_0002, 32'h9910_0001, 32'h9910_0000}, 0, '0);
      vecs[6] = mk(32'hFFFF_FFF0, 1, 7, 4,
                   {32'hFFFF_0003, 32'hFFFF_0002, 32'hFFFF_0001, 32'hFFFF_0000}, 0, '0);

      i_rst_n = 1'b0;
      i_miss  = 1'b0;
      i_maddr = '0;
      i_wbusy = 1'b0;
      i_mack  = 1'b0;
      i_mdata = '0;
      #12;
      check("reset busy/mreq/ie", {o_busy, o_mreq, o_ie}, 3'b000);
      check("reset maddr", o_maddr, 32'h0);
      check("reset iaddr", o_iaddr, 32'h0);
      check("reset idata", o_idata, 128'h0);
`ifdef CACHE_REFILL_CWF_EN
      check("reset cw", {o_cwvalid, o_cwdata}, 33'h0);
`endif
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < 7; i++) begin
         run_refill(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of FETCH after two beats.
      i_miss  = 1'b1;
      i_maddr = 32'h0000_5674;
      @(posedge i_clk); #1;
      i_miss  = 1'b0;
      i_mack  = 1'b1;
      i_mdata = 32'hDEAD_0000;
      @(posedge i_clk); #1;
      i_mdata = 32'hDEAD_0001;
      @(posedge i_clk); #1;
      i_mack  = 1'b0;
      #2;
      check("pre-reset still fetching", o_mreq, 1'b1);
      i_rst_n = 1'b0;
      #1;
      check("async reset busy/mreq/ie", {o_busy, o_mreq, o_ie}, 3'b000);
      check("async reset maddr", o_maddr, 32'h0);
      check("async reset iaddr", o_iaddr, 32'h0);
      check("async reset idata", o_idata, 128'h0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      rv = mk(32'h0000_5674, 0, 0, 0,
              {32'h5670_0003, 32'h5670_0002, 32'h5670_0001, 32'h5670_0000}, 0, '0);
      run_refill(rv, "post-reset");

      // Randomized refills; busy windows either end before the fetch ends or
      // straddle its last beat, as a pending cache write would.
      for (int i = 0; i < 20; i++) begin
         int w, e4;
         w  = int'($urandom_range(0, 2));
         e4 = 4 * (w + 1);
         rv = mk($urandom, w, int'($urandom_range(0, e4 - 1)), int'($urandom_range(0, 4)),
                 {$urandom, $urandom, $urandom, $urandom}, 0, '0);
         run_refill(rv, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
